// File: rtl/dino_vga_timing.sv
// -----------------------------------------------------------------------------
// dino_vga_timing
//
// Purpose:
//   VGA raster timing generator. Two counters walk the raster one pixel per
//   enabled clock: hpos runs 0..H_TOTAL-1 along a line, and vpos advances
//   once per line through 0..V_TOTAL-1. The sync, visible-area and
//   end-of-line/frame flags are decoded from those positions.
//
// Ports:
//   clk        in   pixel clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset (release synchronised
//                   externally)
//   tick_en    in   pixel advance enable; everything holds while low
//   hpos       out  [9:0] current pixel column, 0..H_TOTAL-1
//   vpos       out  [9:0] current line, 0..V_TOTAL-1
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   display_on out  high while (hpos,vpos) lies in the visible area
//   line_end   out  high on the last pixel of every line
//   frame_end  out  high on the last pixel of the last line
// -----------------------------------------------------------------------------
module dino_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 10 bits wide, so neither total may exceed 1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
        $error("dino_vga_timing: H_TOTAL (%0d) and V_TOTAL (%0d) must be <= 1024",
               H_TOTAL, V_TOTAL);
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Window bounds are one bit wider than the counters: an end bound may
    // legitimately equal 1024 when a porch is zero.
    localparam logic [10:0] H_VIS_END   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    // Next raster position. With tick_en low the position simply holds.
    always_comb begin
        h_next = hpos;
        v_next = vpos;
        if (tick_en) begin
            if (hpos == H_LAST) begin
                h_next = '0;
                v_next = (vpos == V_LAST) ? '0 : vpos + 10'd1;
            end else begin
                h_next = hpos + 10'd1;
            end
        end
    end

    assign h_ext = {1'b0, h_next};
    assign v_ext = {1'b0, v_next};

    // The flags are decoded from the *next* position and registered together
    // with it, so every flag lines up with the hpos/vpos it describes in the
    // same cycle while still coming straight out of a flop (glitch-free, and
    // no combinational path from tick_en to any output).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos       <= '0;
            vpos       <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b1;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            hpos       <= h_next;
            vpos       <= v_next;
            hsync      <= !((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END));
            vsync      <= !((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END));
            display_on <= (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
            line_end   <= (h_next == H_LAST);
            frame_end  <= (h_next == H_LAST) && (v_next == V_LAST);
        end
    end

endmodule

// File: doc/dino_vga_timing.md
DINO_VGA_TIMING -- requirements
Module: dino_vga_timing

Interface
REQ-001 Parameters (name, default, meaning), one per line; all SHALL be elaboration-time integers:
  H_ACTIVE 640, visible pixels per line
  H_FP 16, horizontal front porch
  H_SYNC 96, hsync width
  H_BP 48, horizontal back porch
  V_ACTIVE 480, visible lines per frame
  V_FP 10, vertical front porch
  V_SYNC 2, vsync width
  V_BP 33, vertical back porch
REQ-002 Ports (name, direction, width, meaning):
  clk  input  1  pixel clock; the single clock; all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  tick_en  input  1  pixel advance enable; counters hold when low
  hpos  output  10  current pixel column, 0..H_TOTAL-1
  vpos  output  10  current line, 0..V_TOTAL-1
  hsync  output  1  horizontal sync, active low
  vsync  output  1  vertical sync, active low
  display_on  output  1  high while (hpos,vpos) is in the visible area
  line_end  output  1  high on the last pixel of every line
  frame_end  output  1  high on the last pixel of the last line
REQ-003 The block SHALL have exactly one clock (clk) and one asynchronous active-low reset (rst_n); no other clock or reset input exists.

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both SHALL be <= 1024, otherwise elaboration SHALL fail.
REQ-005 hpos and vpos SHALL be registers; every other output SHALL be a register whose value is a pure function of the hpos/vpos values present in the same cycle (zero relative latency, glitch-free).
REQ-006 On a rising clk edge with tick_en=1: if hpos<H_TOTAL-1, hpos SHALL increment by 1 and vpos SHALL hold.
REQ-007 On a rising clk edge with tick_en=1 and hpos=H_TOTAL-1: hpos SHALL wrap to 0; vpos SHALL increment by 1, or wrap to 0 if vpos=V_TOTAL-1.
REQ-008 On a rising clk edge with tick_en=0, all outputs SHALL hold their values, including line_end/frame_end (level, not one-shot).
REQ-009 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (default 656..751), else 1.
REQ-010 vsync SHALL be 0 iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (default 490..491), else 1; vsync SHALL change only with vpos, i.e. at hpos=0.
REQ-011 display_on SHALL be 1 iff hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-012 line_end SHALL be 1 iff hpos=H_TOTAL-1; frame_end SHALL be 1 iff hpos=H_TOTAL-1 and vpos=V_TOTAL-1.
REQ-013 Counter arithmetic SHALL be 10-bit unsigned; hpos/vpos SHALL never reach H_TOTAL/V_TOTAL or higher.
REQ-014 The block SHALL contain no state machine beyond the two counters and the registered decodes; no combinational path SHALL exist from tick_en to any output.

Reset
REQ-015 When rst_n=0, asynchronously and independent of clk: hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, line_end=0, frame_end=0.
REQ-016 Reset asserted mid-line or mid-frame SHALL abort the frame immediately; after release, the first enabled clk edge SHALL give hpos=1, vpos=0.
REQ-017 Release of rst_n SHALL be assumed synchronised externally; no internal reset synchroniser is required.

Verification
REQ-018 Reset then tick_en=1 for 800 cycles -> hpos 0..799 then 0, vpos 0->1 at the wrap; line_end high exactly at hpos=799.
REQ-019 Free-run 420000 cycles (one frame) -> exactly 525 line_end pulses, one frame_end at (799,524), then (0,0) with display_on=1.
REQ-020 Check sync windows -> hsync low for exactly 96 cycles starting at hpos=656; vsync low for exactly 1600 cycles starting at (0,490).
REQ-021 display_on count per frame -> exactly 307200 high cycles; low at hpos=640 and at vpos=480.
REQ-022 Drop tick_en for 5 cycles at hpos=799,vpos=524 -> all outputs frozen (frame_end stays 1), then wrap to (0,0) on first enabled edge.
REQ-023 Assert rst_n=0 asynchronously at (300,200) between clk edges -> outputs reach reset values before the next edge; after release counting restarts from (0,0).
